mux_4to1: RTL and testbench
===========================

Name: mux_4to1

Overview:
- Registered 4-to-1 multiplexer for the datapath's general operand/result selection (ROM/register-file read paths).
- Selects one of four WIDTH-bit inputs by a 2-bit select and presents it on a registered output one clock later.
- Provides an output-valid flag and an echo of the select that produced the current output, for downstream alignment.

Parameters:
- WIDTH, 32, bit width of each data input and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; output registers load only when high.
- in0  input  WIDTH  data input, selected when sel=0.
- in1  input  WIDTH  data input, selected when sel=1.
- in2  input  WIDTH  data input, selected when sel=2.
- in3  input  WIDTH  data input, selected when sel=3.
- sel  input  2  select code, unsigned 0..3.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  high when out holds data captured since reset.
- sel_q  output  2  select value that produced the current out.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high on rst, sampled at the rising edge only.
- Reset values: out=0, out_valid=0, sel_q=0.
- rst has priority over en.
- If rst is asserted mid-stream, out, out_valid and sel_q clear at that edge regardless of en, sel or data.
- On a rising edge with rst=0 and en=1:
  - out <= in[sel], where sel=0→in0, 1→in1, 2→in2, 3→in3.
  - sel_q <= sel.
  - out_valid <= 1.
- On a rising edge with rst=0 and en=0: out, sel_q and out_valid hold their values (no bubble, no clear).
- Latency is exactly 1 cycle from sel/data/en sampled at edge N to out valid after edge N.
- Throughput is 1 selection per cycle, with no internal state beyond the output registers.
- Inputs are sampled only at the clock edge. Changes to in*/sel between edges have no effect on out.
- All 2-bit select codes are legal; there is no default/X case. Data passes bit-exact, with no sign handling or truncation.
- out_valid, once set, stays 1 until the next rst.
- Outputs are driven only by flops; there is no combinational input-to-output path.

Test Plan:
- Reset: in0=0, in1=1, in2=2, in3=3, sel=2, en=1, rst=1 for 2 cycles → out=0, out_valid=0, sel_q=0 at each edge.
- Select sweep: release rst; in0..in3=0,1,2,3, en=1; apply sel=0,1,2,3 on successive cycles → out=0,1,2,3 one cycle later each, with sel_q matching and out_valid=1.
- Width/data integrity: in0=0xFFFFFFFF, in1=0x80000001, in2=0x12345678, in3=0xA5A5A5A5; sweep sel → out equals each pattern bit-exact after 1 cycle.
- Hold: capture sel=3 (out=3), then en=0 and change sel to 0 and in3 to 7 for 3 cycles → out stays 3, sel_q stays 3; raising en=1 with sel=0 → out=0 next cycle.
- Mid-stream reset: while streaming sel=1 (out=1), assert rst=1 with en=1 for one cycle → out=0, out_valid=0 at that edge; deassert → next en=1 capture resumes normally.
- Between-edge glitch: toggle sel 0→3→0 between clock edges with in0=5, in3=9 → out reflects only the value sampled at the edge (5), never 9.

Source files
------------

// File: rtl/mux_4to1.sv
// Registered 4-to-1 operand/result selector.
// One of four WIDTH-bit inputs is chosen by sel and registered on the next
// rising edge, together with a valid flag and an echo of the select.
// Every output comes straight from a flop, so no input reaches an output
// without passing through a clock edge.
module mux_4to1 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       sel_q
);

    logic [WIDTH-1:0] mux_d;

    // Select the data for the output register; all four codes are legal.
    always_comb begin
        mux_d = in0;
        case (sel)
            2'd0: mux_d = in0;
            2'd1: mux_d = in1;
            2'd2: mux_d = in2;
            2'd3: mux_d = in3;
            default: mux_d = in0;
        endcase
    end

    // Output registers: reset wins over enable, and en=0 holds the last capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_q     <= 2'd0;
        end else if (en) begin
            out       <= mux_d;
            out_valid <= 1'b1;
            sel_q     <= sel;
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: directed vector table, a between-edge glitch
// sequence, and randomized traffic against a behavioural reference model.
module tb_mux_4to1;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] in0, in1, in2, in3;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [1:0]       sel_q;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .sel_q     (sel_q)
    );

    typedef struct {
        string                  name;
        logic                   rst;
        logic                   en;
        logic [1:0]             sel;
        logic [3:0][WIDTH-1:0]  d;
        logic [WIDTH-1:0]       exp_out;
        logic                   exp_v;
        logic [1:0]             exp_s;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: what the output registers should hold.
    logic [WIDTH-1:0] m_out;
    logic             m_v;
    logic [1:0]       m_s;
    logic [WIDTH-1:0] m_data [4];

    task automatic add(input string name, input logic r, input logic e,
                       input logic [1:0] s,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] eo, input logic ev,
                       input logic [1:0] es);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.sel = s;
        v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = d;
        v.exp_out = eo; v.exp_v = ev; v.exp_s = es;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [WIDTH-1:0] eo,
                             input logic ev, input logic [1:0] es);
        check({name, ".out"}, out, eo);
        check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({name, ".sel_q"}, {30'd0, sel_q}, {30'd0, es});
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] s,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        rst = r; en = e; sel = s; in0 = a; in1 = b; in2 = c; in3 = d;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, '0, '0, '0, '0);

        // Reset with a live-looking input set
        add("rst0",   1, 1, 2, 0, 1, 2, 3, 0, 0, 0);
        add("rst1",   1, 1, 2, 0, 1, 2, 3, 0, 0, 0);
        // en=0 right after reset must not set valid
        add("idle",   0, 0, 2, 0, 1, 2, 3, 0, 0, 0);
        // Select sweep
        add("sw0",    0, 1, 0, 0, 1, 2, 3, 0, 1, 0);
        add("sw1",    0, 1, 1, 0, 1, 2, 3, 1, 1, 1);
        add("sw2",    0, 1, 2, 0, 1, 2, 3, 2, 1, 2);
        add("sw3",    0, 1, 3, 0, 1, 2, 3, 3, 1, 3);
        // Bit-exact data
        add("bits0",  0, 1, 0, 32'hFFFFFFFF, 32'h80000001, 32'h12345678, 32'hA5A5A5A5, 32'hFFFFFFFF, 1, 0);
        add("bits1",  0, 1, 1, 32'hFFFFFFFF, 32'h80000001, 32'h12345678, 32'hA5A5A5A5, 32'h80000001, 1, 1);
        add("bits2",  0, 1, 2, 32'hFFFFFFFF, 32'h80000001, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 1, 2);
        add("bits3",  0, 1, 3, 32'hFFFFFFFF, 32'h80000001, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 3);
        // Hold with en=0
        add("hcap",   0, 1, 3, 0, 1, 2, 3, 3, 1, 3);
        add("hold0",  0, 0, 0, 0, 1, 2, 7, 3, 1, 3);
        add("hold1",  0, 0, 0, 0, 1, 2, 7, 3, 1, 3);
        add("hold2",  0, 0, 0, 0, 1, 2, 7, 3, 1, 3);
        add("hrel",   0, 1, 0, 0, 1, 2, 7, 0, 1, 0);
        // Mid-stream reset
        add("ms1",    0, 1, 1, 0, 1, 2, 3, 1, 1, 1);
        add("msrst",  1, 1, 1, 0, 1, 2, 3, 0, 0, 0);
        add("msres",  0, 1, 1, 0, 1, 2, 3, 1, 1, 1);
        add("msrst0", 1, 0, 3, 0, 1, 2, 3, 0, 0, 0);
        add("msres3", 0, 1, 3, 0, 1, 2, 3, 3, 1, 3);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].sel,
                  vecs[i].d[0], vecs[i].d[1], vecs[i].d[2], vecs[i].d[3]);
            @(posedge clk);
            #1;
            check_all(vecs[i].name, vecs[i].exp_out, vecs[i].exp_v, vecs[i].exp_s);
        end

        // Between-edge glitch: only the edge-sampled select matters
        drive(1'b0, 1'b1, 2'd0, 32'd5, 32'd1, 32'd2, 32'd9);
        @(posedge clk);
        #1;
        check_all("gl_edge", 32'd5, 1'b1, 2'd0);
        #1 sel = 2'd3;
        #1;
        check_all("gl_mid", 32'd5, 1'b1, 2'd0);
        #1 sel = 2'd0;
        @(posedge clk);
        #1;
        check_all("gl_after", 32'd5, 1'b1, 2'd0);

        // Randomized traffic against the reference model
        m_out = 32'd5; m_v = 1'b1; m_s = 2'd0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) m_data[k] = $urandom;
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  m_data[0], m_data[1], m_data[2], m_data[3]);
            if (rst) begin
                m_out = '0; m_v = 1'b0; m_s = 2'd0;
            end else if (en) begin
                m_out = m_data[sel]; m_v = 1'b1; m_s = sel;
            end
            @(posedge clk);
            #1;
            check_all("rand", m_out, m_v, m_s);
            // Scramble inputs between edges; outputs must not follow
            in0 = ~in0; in1 = ~in1; in2 = ~in2; in3 = ~in3; sel = ~sel; rst = ~rst;
            #2;
            check("rand_mid.out", out, m_out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
